// File: rtl/ps2_scancode_rx_if.sv
// Key-event stream from the PS/2 receiver to its consumer.
// The master drives the head event and the slave drives ev_ready.
interface ps2_scancode_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (
    output ev_valid, ev_code, ev_ext, ev_brk,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_code, ev_ext, ev_brk,
    output ev_ready
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frame deserialiser, prefix decoder
// and key-event FIFO with a valid/ready drain port.
module ps2_scancode_rx #(
  parameter int SYNC_LEN    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MODE        = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk,
  input  logic ps2data,
  ps2_scancode_rx_if.master ev,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic parity_err,
  output logic frame_err,
  output logic timeout_err,
  output logic overflow
);

  localparam int HALF = SYNC_LEN / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TW   = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  logic [SYNC_LEN-1:0] clk_hist;
  logic [1:0]          data_sync;
  logic                fall_edge;
  logic                din;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] wd_cnt;
  logic          ext_pend;
  logic          brk_pend;

  logic wd_hit;
  logic stop_eval;
  logic par_ok;
  logic is_prefix;
  logic push;
  ev_t  push_ev;

  ev_t            mem [FIFO_DEPTH];
  ev_t            hold;
  ev_t            head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           empty;
  logic           pop;
  logic           wr_en;

  // Pin history; the data pin only needs to settle before the
  // debounced clock edge, which lags by HALF cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_hist  <= '0;
      data_sync <= '0;
    end else begin
      clk_hist  <= {clk_hist[SYNC_LEN-2:0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
    end
  end

  assign fall_edge = (&clk_hist[SYNC_LEN-1:HALF]) &&
                     ~(|clk_hist[HALF-1:0]);
  assign din = data_sync[1];

  assign wd_hit    = (state != IDLE) && !fall_edge &&
                     (wd_cnt == TW'(TIMEOUT_CYC - 1));
  assign stop_eval = fall_edge && (state == STOP);
  assign par_ok    = ^{shreg, par_bit};
  assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
  assign push      = stop_eval && par_ok && din && !is_prefix &&
                     ((MODE != 0) || brk_pend);
  assign push_ev   = '{ext: ext_pend, brk: brk_pend, code: shreg};

  // Frame FSM, watchdog, prefix tracking and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      wd_cnt      <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      if (fall_edge || state == IDLE)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + TW'(1);
      if (wd_hit) begin
        state       <= IDLE;
        timeout_err <= 1'b1;
        ext_pend    <= 1'b0;
        brk_pend    <= 1'b0;
      end else if (fall_edge) begin
        unique case (state)
          IDLE: begin
            if (!din) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par_bit <= din;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!par_ok) begin
              parity_err <= 1'b1;
              ext_pend   <= 1'b0;
              brk_pend   <= 1'b0;
            end else if (!din) begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end else if (shreg == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk_pend <= 1'b1;
            end else begin
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && ev.ev_ready;
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  // Event FIFO; hold keeps ev_* stable once the FIFO drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      hold     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      overflow <= push && full && !pop;
      if (wr_en) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (!empty)
        hold <= head;
    end
  end

  assign ev.ev_valid = !empty;
  assign ev.ev_code  = empty ? hold.code : head.code;
  assign ev.ev_ext   = empty ? hold.ext  : head.ext;
  assign ev.ev_brk   = empty ? hold.brk  : head.brk;
  assign fifo_level  = count;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench: a MODE 0 and a MODE 1 receiver share the
// PS/2 pins so each frame sequence exercises both modes.
module tb_ps2_scancode_rx;
  localparam int H = 20;

  logic clk = 1'b0;
  logic reset;
  logic ps2clk;
  logic ps2data;
  logic [3:0] lvl0, lvl1;
  logic pe0, fe0, to0, ov0;
  logic pe1, fe1, to1, ov1;

  int tests = 0;
  int fails = 0;
  int npe0 = 0, npe1 = 0, nfe0 = 0, nfe1 = 0;
  int nto0 = 0, nto1 = 0, nov0 = 0, nov1 = 0;

  ps2_scancode_rx_if e0 ();
  ps2_scancode_rx_if e1 ();

  ps2_scancode_rx #(
    .SYNC_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYC(200), .MODE(0)
  ) u0 (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev(e0), .fifo_level(lvl0), .parity_err(pe0),
    .frame_err(fe0), .timeout_err(to0), .overflow(ov0)
  );

  ps2_scancode_rx #(
    .SYNC_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYC(200), .MODE(1)
  ) u1 (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev(e1), .fifo_level(lvl1), .parity_err(pe1),
    .frame_err(fe1), .timeout_err(to1), .overflow(ov1)
  );

  always #5 clk = ~clk;

  // Pulse counters.
  always @(posedge clk) begin
    if (pe0) npe0++;
    if (pe1) npe1++;
    if (fe0) nfe0++;
    if (fe1) nfe1++;
    if (to0) nto0++;
    if (to1) nto1++;
    if (ov0) nov0++;
    if (ov1) nov1++;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic send_frame(input logic [7:0] b,
                            input logic bad_par,
                            input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2data = bits[i];
      repeat (H) @(negedge clk);
      ps2clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic drain();
    e0.ev_ready = 1'b1;
    e1.ev_ready = 1'b1;
    repeat (20) @(negedge clk);
    e0.ev_ready = 1'b0;
    e1.ev_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ps2clk = 1'b1;
    ps2data = 1'b1;
    e0.ev_ready = 1'b0;
    e1.ev_ready = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({e0.ev_valid, e1.ev_valid, lvl0, lvl1} !== 10'd0) begin
      fails++;
      $display("FAIL reset_level: got %b %b %0d %0d want 0 0 0 0",
               e0.ev_valid, e1.ev_valid, lvl0, lvl1);
    end
    tests++;
    if ({e1.ev_code, e1.ev_ext, e1.ev_brk} !== 10'd0) begin
      fails++;
      $display("FAIL reset_ev: got %h %b %b want 00 0 0",
               e1.ev_code, e1.ev_ext, e1.ev_brk);
    end
    tests++;
    if ({pe0, fe0, to0, ov0, pe1, fe1, to1, ov1} !== 8'd0) begin
      fails++;
      $display("FAIL reset_err: got %b want 0",
               {pe0, fe0, to0, ov0, pe1, fe1, to1, ov1});
    end
  endtask

  task automatic test_make();
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    tests++;
    if ({e1.ev_valid, e1.ev_code, e1.ev_ext, e1.ev_brk} !==
        {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL make_m1: got v%b %h e%b b%b want v1 1c e0 b0",
               e1.ev_valid, e1.ev_code, e1.ev_ext, e1.ev_brk);
    end
    tests++;
    if (e0.ev_valid !== 1'b0) begin
      fails++;
      $display("FAIL make_m0: got valid %b want 0", e0.ev_valid);
    end
    e1.ev_ready = 1'b1;
    @(negedge clk);
    e1.ev_ready = 1'b0;
    tests++;
    if ({e1.ev_valid, lvl1} !== 5'd0) begin
      fails++;
      $display("FAIL make_pop: got v%b lvl %0d want v0 lvl 0",
               e1.ev_valid, lvl1);
    end
    tests++;
    if (e1.ev_code !== 8'h1C) begin
      fails++;
      $display("FAIL make_hold: got %h want 1c", e1.ev_code);
    end
  endtask

  task automatic test_break_mode0();
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    tests++;
    if ({lvl0, e0.ev_code, e0.ev_ext, e0.ev_brk} !==
        {4'd1, 8'h1C, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL brk_m0: got lvl %0d %h e%b b%b want 1 1c e0 b1",
               lvl0, e0.ev_code, e0.ev_ext, e0.ev_brk);
    end
    tests++;
    if (lvl1 !== 4'd2) begin
      fails++;
      $display("FAIL brk_m1_lvl: got %0d want 2", lvl1);
    end
    drain();
  endtask

  task automatic test_ext();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    tests++;
    if ({lvl1, e1.ev_code, e1.ev_ext, e1.ev_brk} !==
        {4'd2, 8'h75, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL ext_first: got lvl %0d %h e%b b%b want 2 75 e1 b1",
               lvl1, e1.ev_code, e1.ev_ext, e1.ev_brk);
    end
    tests++;
    if ({lvl0, e0.ev_code, e0.ev_ext, e0.ev_brk} !==
        {4'd1, 8'h75, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL ext_m0: got lvl %0d %h e%b b%b want 1 75 e1 b1",
               lvl0, e0.ev_code, e0.ev_ext, e0.ev_brk);
    end
    e1.ev_ready = 1'b1;
    @(negedge clk);
    e1.ev_ready = 1'b0;
    tests++;
    if ({e1.ev_valid, e1.ev_code, e1.ev_ext, e1.ev_brk} !==
        {1'b1, 8'h75, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL ext_second: got v%b %h e%b b%b want v1 75 e0 b0",
               e1.ev_valid, e1.ev_code, e1.ev_ext, e1.ev_brk);
    end
    drain();
  endtask

  task automatic test_errors();
    int p0, p1, f0;
    p0 = npe0;
    p1 = npe1;
    f0 = nfe0;
    send_frame(8'h1C, 1'b1, 1'b1);
    tests++;
    if ({npe0 - p0, npe1 - p1, nfe0 - f0} !== {32'd1, 32'd1, 32'd0}) begin
      fails++;
      $display("FAIL parity_pulse: got %0d %0d fe %0d want 1 1 0",
               npe0 - p0, npe1 - p1, nfe0 - f0);
    end
    tests++;
    if ({lvl0, lvl1} !== 8'd0) begin
      fails++;
      $display("FAIL parity_drop: got %0d %0d want 0 0", lvl0, lvl1);
    end
    f0 = nfe0;
    p0 = npe0;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h2D, 1'b0, 1'b0);
    tests++;
    if ({nfe0 - f0, npe0 - p0, lvl0} !== {32'd1, 32'd0, 4'd0}) begin
      fails++;
      $display("FAIL frame_err: got fe %0d pe %0d lvl %0d want 1 0 0",
               nfe0 - f0, npe0 - p0, lvl0);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    tests++;
    if ({lvl0, e0.ev_code, e0.ev_brk} !== {4'd1, 8'h1C, 1'b0} &&
        lvl0 !== 4'd0) begin
      fails++;
      $display("FAIL frame_clear: got lvl %0d want 0", lvl0);
    end
    tests++;
    if (lvl0 !== 4'd0) begin
      fails++;
      $display("FAIL brk_cleared: got lvl %0d want 0", lvl0);
    end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    tests++;
    if ({lvl0, e0.ev_code, e0.ev_brk} !== {4'd1, 8'h1C, 1'b1}) begin
      fails++;
      $display("FAIL after_err: got lvl %0d %h b%b want 1 1c b1",
               lvl0, e0.ev_code, e0.ev_brk);
    end
    drain();
  endtask

  task automatic test_timeout();
    logic [4:0] pb;
    int n;
    bit seen;
    pb = 5'b11000;
    send_frame(8'hF0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      ps2data = pb[i];
      repeat (H) @(negedge clk);
      ps2clk = 1'b0;
      if (i < 4) begin
        repeat (H) @(negedge clk);
        ps2clk = 1'b1;
      end
    end
    n = 0;
    seen = 1'b0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      n++;
      if (n == H) begin
        ps2clk = 1'b1;
        ps2data = 1'b1;
      end
      if (to0) seen = 1'b1;
    end
    tests++;
    if (!seen || n < 203 || n > 207) begin
      fails++;
      $display("FAIL timeout_time: got seen %b at %0d want 1 at 205",
               seen, n);
    end
    tests++;
    if (to1 !== 1'b1) begin
      fails++;
      $display("FAIL timeout_m1: got %b want 1", to1);
    end
    @(negedge clk);
    tests++;
    if (to0 !== 1'b0) begin
      fails++;
      $display("FAIL timeout_width: got %b want 0", to0);
    end
    repeat (40) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    tests++;
    if ({lvl1, e1.ev_code, e1.ev_ext, e1.ev_brk} !==
        {4'd1, 8'h1C, 1'b0, 1'b0} || lvl0 !== 4'd0) begin
      fails++;
      $display("FAIL timeout_next: got %0d %h e%b b%b m0 %0d want 1 1c e0 b0 m0 0",
               lvl1, e1.ev_code, e1.ev_ext, e1.ev_brk, lvl0);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    int o1;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
              8'h35, 8'h3C, 8'h43, 8'h44};
    o1 = nov1;
    for (int i = 0; i < 9; i++)
      send_frame(codes[i], 1'b0, 1'b1);
    tests++;
    if ({lvl1, nov1 - o1} !== {4'd8, 32'd1}) begin
      fails++;
      $display("FAIL ovf_full: got lvl %0d ovf %0d want 8 1",
               lvl1, nov1 - o1);
    end
    e1.ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({e1.ev_valid, e1.ev_code} !== {1'b1, codes[i]}) begin
        fails++;
        $display("FAIL drain_%0d: got v%b %h want v1 %h",
                 i, e1.ev_valid, e1.ev_code, codes[i]);
      end
      @(negedge clk);
    end
    e1.ev_ready = 1'b0;
    tests++;
    if ({e1.ev_valid, lvl1, e1.ev_code} !== {1'b0, 4'd0, 8'h43}) begin
      fails++;
      $display("FAIL drain_end: got v%b lvl %0d %h want v0 0 43",
               e1.ev_valid, lvl1, e1.ev_code);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break_mode0();
    test_ext();
    test_errors();
    test_timeout();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Parametrised PS/2 keyboard receiver. Successor to the release-only scancode receiver.
- Synchronises ps2clk/ps2data, deserialises 11-bit frames, checks start, parity and stop bits, and runs a mid-frame timeout watchdog.
- Decodes E0 (extended) and F0 (break) prefixes into tagged key events.
- Events are buffered in a FIFO drained over a valid/ready handshake. Sits between the PS/2 pins and the calculator/command front-end.

Parameters:
- SYNC_LEN, 8: ps2clk sample-history length, even and ≥4. Falling edge = upper SYNC_LEN/2 samples all 1 and lower SYNC_LEN/2 all 0.
- FIFO_DEPTH, 8: event FIFO entries, power of 2, ≥2.
- TIMEOUT_CYC, 50000: clk cycles with no ps2clk falling edge while mid-frame before the frame is aborted.
- MODE, 0: 0 = enqueue break (release) events only, the legacy behaviour. 1 = enqueue make and break events.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2clk  in  1  raw PS/2 clock, asynchronous
- ps2data  in  1  raw PS/2 data, asynchronous
- ev_valid  out  1  FIFO non-empty; head event on ev_* is valid
- ev_ready  in  1  consumer accepts the head event
- ev_code  out  8  scancode byte of the head event
- ev_ext  out  1  head event was preceded by E0
- ev_brk  out  1  head event was preceded by F0 (release)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of stored events
- parity_err  out  1  1-cycle pulse: frame dropped on parity failure
- frame_err  out  1  1-cycle pulse: frame dropped on bad stop bit
- timeout_err  out  1  1-cycle pulse: frame aborted by the watchdog
- overflow  out  1  1-cycle pulse: event dropped because the FIFO was full

Behaviour:
- Reset (async): sample history = 0, FSM = IDLE, timeout counter = 0, ext_pend = brk_pend = 0, FIFO empty, fifo_level = 0, ev_valid = 0, ev_code/ev_ext/ev_brk = 0, all error pulses = 0. Asserting reset mid-frame discards the partial frame and pending prefixes.
- Sampling: ps2clk is shifted into the SYNC_LEN history every clk. ps2data is sampled on the clk cycle in which fall_edge is true.
- FSM, advancing only on fall_edge:
  - IDLE: ps2data = 0 moves to DATA with bit count 0. ps2data = 1 is ignored and the FSM stays in IDLE.
  - DATA: shift ps2data in LSB-first. After the 8th bit, move to PARITY.
  - PARITY: store the parity bit and move to STOP.
  - STOP: evaluate the frame and return to IDLE.
- Frame check in STOP:
  - XOR of data[7:0] and the parity bit must be 1 (odd parity); otherwise parity_err pulses.
  - The stop bit must be 1; otherwise frame_err pulses.
  - If both fail, only parity_err pulses.
  - An errored frame is dropped and clears ext_pend and brk_pend.
- Watchdog:
  - The counter clears on every fall_edge and while in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYC-1, the FSM returns to IDLE, timeout_err pulses, and ext_pend/brk_pend clear.
  - A fall_edge in the same cycle takes priority; no timeout occurs.
- Prefix decode for a good frame:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte B forms the event {ext_pend, brk_pend, B} and clears both pend flags.
  - MODE 0: enqueue only if brk_pend = 1. MODE 1: always enqueue.
  - E0 12 / E0 F0 12 fake-shift sequences are delivered as ordinary ext events; they are not filtered.
- FIFO:
  - Write occurs on the STOP-evaluation cycle. ev_valid rises 1 clk later when the FIFO was empty.
  - First-word-fall-through: ev_code/ev_ext/ev_brk are driven from the head entry. ev_* hold their value while ev_valid = 0.
  - A pop occurs when ev_valid && ev_ready. ev_ready with ev_valid = 0 is a no-op.
  - Full with a push and no pop: the event is dropped and overflow pulses. Full with simultaneous push and pop: both occur and no overflow.
  - Empty with a push: ev_valid = 1 the next cycle. No same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Error pulses are registered and last exactly 1 clk.

Test Plan:
- MODE=1: frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> one event code=1C ext=0 brk=0; ev_valid held until ev_ready.
- MODE=0: frames 1C, F0, 1C -> exactly one event code=1C brk=1 ext=0; fifo_level = 1.
- MODE=1: frames E0, F0, 75 -> event code=75 ext=1 brk=1; a following 75 yields ext=0 brk=0, confirming the prefixes cleared.
- Frame 0x1C with parity bit 1 -> parity_err pulses once, no event; a subsequent good F0+1C in MODE 0 delivers code=1C.
- TIMEOUT_CYC=200: start bit plus 4 data bits, then ps2clk held high -> timeout_err at 200 clk after the last edge, FSM back in IDLE; the next full frame 0x1C is received correctly.
- FIFO_DEPTH=8, MODE=1, ev_ready=0: 9 make codes -> fifo_level = 8 and overflow pulses once on the 9th. Then ev_ready=1 -> the first 8 codes are drained in order and ev_valid drops.
